// File: rtl/ram_arbiter.sv
// Two-requester (CPU / video) arbiter for a single-port registered RAM.
// Fixed four-cycle access: IDLE -> ISSUE -> CAPTURE -> ACK.
module ram_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 8,
  parameter int MAX_VID_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wena,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vid_req,
  input  logic              vid_wena,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic [DATA_W-1:0] vid_wdata,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              ram_en,
  output logic              ram_wena,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              grant_vid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_ACK
  } state_t;

  localparam logic [3:0] MAXB = 4'(MAX_VID_BURST);

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_burst;
  logic                r_gv;
  logic                r_wena;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_cpu_rdata;
  logic [DATA_W-1:0]   r_vid_rdata;
  logic                w_any;
  logic                w_pick_vid;
  logic                w_grant;

  assign w_any   = cpu_req | vid_req;
  // Video wins ties until it has starved the CPU for MAX_VID_BURST grants.
  assign w_pick_vid = vid_req &
                      (~cpu_req | (r_burst != MAXB));
  assign w_grant = (r_state == S_IDLE) & w_any;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (w_any) w_next = S_ISSUE;
      S_ISSUE:   w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_ACK;
      S_ACK:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_burst     <= 4'd0;
      r_gv        <= 1'b0;
      r_wena      <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_vid_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_gv    <= w_pick_vid;
        r_wena  <= w_pick_vid ? vid_wena  : cpu_wena;
        r_addr  <= w_pick_vid ? vid_addr  : cpu_addr;
        r_wdata <= w_pick_vid ? vid_wdata : cpu_wdata;
        if (w_pick_vid && cpu_req)
          r_burst <= (r_burst == MAXB) ? MAXB
                                       : r_burst + 4'd1;
        else
          r_burst <= 4'd0;
      end
      if (r_state == S_CAPTURE && !r_wena) begin
        if (r_gv) r_vid_rdata <= ram_rdata;
        else      r_cpu_rdata <= ram_rdata;
      end
    end
  end

  assign ram_en    = (r_state == S_ISSUE);
  assign ram_wena  = ram_en & r_wena;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign cpu_ack   = (r_state == S_ACK) & ~r_gv;
  assign vid_ack   = (r_state == S_ACK) &  r_gv;
  assign cpu_rdata = r_cpu_rdata;
  assign vid_rdata = r_vid_rdata;
  assign busy      = (r_state != S_IDLE);
  assign grant_vid = r_gv;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter; RAM model returns addr[7:0]^0x91
// one cycle after a read enable.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_wena;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        vid_req, vid_wena;
  logic [15:0] vid_addr;
  logic [7:0]  vid_wdata;
  logic        vid_ack;
  logic [7:0]  vid_rdata;
  logic        ram_en, ram_wena;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = 8'h00;
  logic        busy, grant_vid;

  int n_chk = 0;
  int n_fail = 0;

  ram_arbiter #(
    .ADDR_W(16), .DATA_W(8), .MAX_VID_BURST(4)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wena(cpu_wena),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_wena(vid_wena),
    .vid_addr(vid_addr), .vid_wdata(vid_wdata),
    .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .ram_en(ram_en), .ram_wena(ram_wena),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .busy(busy), .grant_vid(grant_vid)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (ram_en && !ram_wena)
      ram_rdata <= ram_addr[7:0] ^ 8'h91;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit   got_v [10];
    int   got_c [10];
    bit   exp_v [10];
    int   n_ack;
    exp_v = '{1,1,1,1,0,1,1,1,1,0};

    reset = 1'b1;
    cpu_req = 0; cpu_wena = 0;
    cpu_addr = '0; cpu_wdata = '0;
    vid_req = 0; vid_wena = 0;
    vid_addr = '0; vid_wdata = '0;
    step(); step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ram_en", 32'(ram_en), 0);
    chk("rst_ram_wena", 32'(ram_wena), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_wdata", 32'(ram_wdata), 0);
    chk("rst_grant", 32'(grant_vid), 0);
    chk("rst_acks", 32'({cpu_ack, vid_ack}), 0);
    chk("rst_rdata", 32'({cpu_rdata, vid_rdata}), 0);
    reset = 1'b0;
    step();

    // CPU read 0x1234, req dropped during ISSUE
    cpu_req = 1; cpu_wena = 0; cpu_addr = 16'h1234;
    step();
    chk("rd_c1_en", 32'(ram_en), 1);
    chk("rd_c1_addr", 32'(ram_addr), 32'h1234);
    chk("rd_c1_wena", 32'(ram_wena), 0);
    chk("rd_c1_gv", 32'(grant_vid), 0);
    cpu_req = 0;
    step();
    chk("rd_c2_en", 32'(ram_en), 0);
    chk("rd_c2_ack", 32'(cpu_ack), 0);
    step();
    chk("rd_c3_cack", 32'(cpu_ack), 1);
    chk("rd_c3_vack", 32'(vid_ack), 0);
    chk("rd_c3_rdata", 32'(cpu_rdata), 32'hA5);
    step();
    chk("rd_c4_ack", 32'(cpu_ack), 0);
    chk("rd_c4_busy", 32'(busy), 0);
    step();
    chk("rd_c5_busy", 32'(busy), 0);

    // Video read 0x0011 -> 0x80
    vid_req = 1; vid_wena = 0; vid_addr = 16'h0011;
    step(); vid_req = 0;
    chk("vr_c1_gv", 32'(grant_vid), 1);
    step(); step();
    chk("vr_c3_vack", 32'(vid_ack), 1);
    chk("vr_c3_rdata", 32'(vid_rdata), 32'h80);
    step();

    // Video write 0x5A to 0x0400
    vid_req = 1; vid_wena = 1;
    vid_addr = 16'h0400; vid_wdata = 8'h5A;
    step(); vid_req = 0; vid_wena = 0;
    chk("vw_c1_en", 32'(ram_en), 1);
    chk("vw_c1_wena", 32'(ram_wena), 1);
    chk("vw_c1_wdata", 32'(ram_wdata), 32'h5A);
    chk("vw_c1_addr", 32'(ram_addr), 32'h0400);
    step();
    chk("vw_c2_wena", 32'(ram_wena), 0);
    chk("vw_c2_hold", 32'(ram_addr), 32'h0400);
    step();
    chk("vw_c3_vack", 32'(vid_ack), 1);
    chk("vw_c3_cack", 32'(cpu_ack), 0);
    chk("vw_c3_vrd", 32'(vid_rdata), 32'h80);
    chk("vw_c3_crd", 32'(cpu_rdata), 32'hA5);
    step();

    // Address change while access in flight
    cpu_req = 1; cpu_wena = 0; cpu_addr = 16'h0010;
    step();
    chk("ac_c1_addr", 32'(ram_addr), 32'h0010);
    cpu_addr = 16'h0020;
    step();
    chk("ac_c2_addr", 32'(ram_addr), 32'h0010);
    step();
    chk("ac_c3_ack", 32'(cpu_ack), 1);
    chk("ac_c3_rdata", 32'(cpu_rdata), 32'h81);
    cpu_req = 0;
    step();

    // Both held: 4 video grants then 1 CPU, repeating
    cpu_req = 1; cpu_addr = 16'h0001;
    vid_req = 1; vid_addr = 16'h0002;
    n_ack = 0;
    for (int c = 1; c <= 60 && n_ack < 10; c++) begin
      step();
      if (cpu_ack && vid_ack)
        chk("bu_both_ack", 32'({cpu_ack, vid_ack}), 32'h1);
      if (cpu_ack || vid_ack) begin
        got_v[n_ack] = vid_ack;
        got_c[n_ack] = c;
        n_ack++;
        if (n_ack == 10) begin
          cpu_req = 0; vid_req = 0;
        end
      end
    end
    chk("bu_count", 32'(n_ack), 10);
    for (int k = 0; k < n_ack; k++) begin
      chk($sformatf("bu_owner%0d", k),
          32'(got_v[k]), 32'(exp_v[k]));
      chk($sformatf("bu_cycle%0d", k),
          32'(got_c[k]), 32'(3 + 4 * k));
    end
    chk("bu_crd", 32'(cpu_rdata), 32'h90);
    chk("bu_vrd", 32'(vid_rdata), 32'h93);
    step(); step();
    chk("bu_idle", 32'(busy), 0);

    // Reset during CAPTURE aborts the access
    cpu_req = 1; cpu_addr = 16'h0030;
    step(); cpu_req = 0;
    step();
    chk("rs_c2_busy", 32'(busy), 1);
    reset = 1;
    step();
    reset = 0;
    chk("rs_busy", 32'(busy), 0);
    chk("rs_ack", 32'({cpu_ack, vid_ack}), 0);
    chk("rs_en", 32'(ram_en), 0);
    chk("rs_addr", 32'(ram_addr), 0);
    chk("rs_gv", 32'(grant_vid), 0);
    chk("rs_rdata", 32'({cpu_rdata, vid_rdata}), 0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("rs_noack", 32'({cpu_ack, vid_ack, busy}), 0);
    end
    vid_req = 1; vid_addr = 16'h0044;
    step(); vid_req = 0;
    chk("rs_new_en", 32'(ram_en), 1);
    step(); step();
    chk("rs_new_ack", 32'(vid_ack), 1);
    chk("rs_new_rdata", 32'(vid_rdata), 32'hD5);
    step();
    chk("rs_new_idle", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
